// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt controller: register byte addresses
// and the widest supported pin count.
package gpio_irq_pkg;

    localparam int MAX_W = 32;

    localparam logic [7:0] ADDR_DATA_IN    = 8'h00;
    localparam logic [7:0] ADDR_DATA_OUT   = 8'h04;
    localparam logic [7:0] ADDR_DIR        = 8'h08;
    localparam logic [7:0] ADDR_OUT_SET    = 8'h0C;
    localparam logic [7:0] ADDR_OUT_CLR    = 8'h10;
    localparam logic [7:0] ADDR_RISE_EN    = 8'h14;
    localparam logic [7:0] ADDR_FALL_EN    = 8'h18;
    localparam logic [7:0] ADDR_IRQ_STATUS = 8'h1C;

endpackage

// File: rtl/gpio_in_filter.sv
// One pin's input conditioning: SYNC_STAGES-deep synchroniser, followed by a
// stability counter when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int DB_CYCLES = 4
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic fin_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             db_fin_q;

    // Any sample that agrees with the current filtered value restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            db_fin_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] != db_fin_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_fin_q <= sync_q[SYNC_STAGES-1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign fin_o = db_fin_q;
`else
    assign fin_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO controller with direction, atomic set/clear and W1C edge interrupts.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int DB_CYCLES = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    logic [GPIO_W-1:0] fin;
    logic [GPIO_W-1:0] fin_q;
    logic [GPIO_W-1:0] data_out_q, data_out_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] rise_en_q, rise_en_d;
    logic [GPIO_W-1:0] fall_en_q, fall_en_d;
    logic [GPIO_W-1:0] status_q, status_d;
    logic [GPIO_W-1:0] edge_set;
    logic [GPIO_W-1:0] w1c_mask;
    logic [GPIO_W-1:0] wdata_w;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       rd_word;

    for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
        gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            , .DB_CYCLES (DB_CYCLES)
`endif
        ) u_filter (
            .clk   (clk),
            .rst   (rst),
            .pin_i (gpio_in[g]),
            .fin_o (fin[g])
        );
    end

    assign wdata_w = wdata[GPIO_W-1:0];

    // Output-direction pins are excluded from edge detection.
    assign edge_set = ~dir_q & ((fin & ~fin_q & rise_en_q) | (~fin & fin_q & fall_en_q));
    assign w1c_mask = (wr_en && addr == ADDR_IRQ_STATUS) ? wdata_w : '0;
    assign status_d = (status_q & ~w1c_mask) | edge_set;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        if (wr_en) begin
            case (addr)
                ADDR_DATA_OUT: data_out_d = wdata_w;
                ADDR_DIR:      dir_d      = wdata_w;
                ADDR_OUT_SET:  data_out_d = data_out_q | wdata_w;
                ADDR_OUT_CLR:  data_out_d = data_out_q & ~wdata_w;
                ADDR_RISE_EN:  rise_en_d  = wdata_w;
                ADDR_FALL_EN:  fall_en_d  = wdata_w;
                default: ;
            endcase
        end
    end

    // Read mux sees pre-write state, so a simultaneous write is not reflected.
    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_DATA_IN:    rd_word[GPIO_W-1:0] = fin;
            ADDR_DATA_OUT:   rd_word[GPIO_W-1:0] = data_out_q;
            ADDR_DIR:        rd_word[GPIO_W-1:0] = dir_q;
            ADDR_RISE_EN:    rd_word[GPIO_W-1:0] = rise_en_q;
            ADDR_FALL_EN:    rd_word[GPIO_W-1:0] = fall_en_q;
            ADDR_IRQ_STATUS: rd_word[GPIO_W-1:0] = status_q;
            default: ;
        endcase
    end

    assign rdata_d = rd_en ? rd_word : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_q      <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
        end else begin
            fin_q      <= fin;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl with a history-based reference model.
module tb_gpio_irq_ctrl;

    localparam int W = 32;
    localparam int S = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB  = 4;
    localparam int LAT = S + DB + 1;
`else
    localparam int LAT = S + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    gpio_irq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: pin samples per clock edge since reset, and the
    // filtered value that results after each edge.
    logic [31:0] m_out, m_dir, m_rise, m_fall, m_status, m_rdata;
    logic [31:0] vh[$];
    logic [31:0] fh[$];
    logic [31:0] pins = '0;

    function automatic logic [31:0] pin_at(int k);
        if (k < 0 || k >= vh.size()) return '0;
        return vh[k];
    endfunction

    function automatic logic [31:0] fin_at(int k);
        if (k < 0 || k >= fh.size()) return '0;
        return fh[k];
    endfunction

    function automatic logic [31:0] next_fin(int k);
`ifdef GPIO_DEBOUNCE_EN
        logic [31:0] r, v;
        logic        all_diff;
        r = fin_at(k - 1);
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (k - j < 0) all_diff = 1'b0;
                else begin
                    v = pin_at(k - j - S);
                    if (v[b] == r[b]) all_diff = 1'b0;
                end
            end
            if (all_diff) r[b] = ~r[b];
        end
        return r;
`else
        return pin_at(k - S + 1);
`endif
    endfunction

    function automatic logic [31:0] model_read(logic [7:0] a);
        case (a)
            8'h00:   return fin_at(vh.size() - 1);
            8'h04:   return m_out;
            8'h08:   return m_dir;
            8'h14:   return m_rise;
            8'h18:   return m_fall;
            8'h1C:   return m_status;
            default: return '0;
        endcase
    endfunction

    task automatic model_clear();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0; m_rdata = '0;
        vh.delete();
        fh.delete();
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        logic [31:0] fprev, fprev2, set, w1c;
        int k;
        wr_en = w; rd_en = r; addr = a; wdata = d; gpio_in = p; pins = p;
        @(posedge clk);
        k      = vh.size();
        fprev  = fin_at(k - 1);
        fprev2 = fin_at(k - 2);
        if (r) m_rdata = model_read(a);
        set = ~m_dir & ((fprev & ~fprev2 & m_rise) | (~fprev & fprev2 & m_fall));
        w1c = (w && a == 8'h1C) ? d : '0;
        m_status = (m_status & ~w1c) | set;
        if (w) begin
            case (a)
                8'h04: m_out  = d;
                8'h08: m_dir  = d;
                8'h0C: m_out  = m_out | d;
                8'h10: m_out  = m_out & ~d;
                8'h14: m_rise = d;
                8'h18: m_fall = d;
                default: ;
            endcase
        end
        vh.push_back(p);
        fh.push_back(next_fin(k));
        #1;
    endtask

    task automatic idle(input logic [31:0] p);
        cycle(1'b0, 1'b0, 8'h00, 32'h0, p);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, a, d, pins);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b0, 1'b1, a, 32'h0, pins);
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        logic [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
        pins = '0; gpio_in = '0;
        do_reset();
        n_checks++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_checks++;
        if (gpio_out !== 32'h0) begin n_err++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
        n_checks++;
        if (gpio_oe !== 32'h0) begin n_err++; $display("FAIL reset_gpio_oe: got %h want 0", gpio_oe); end
        n_checks++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        foreach (addrs[i]) begin
            rd(addrs[i]);
            n_checks++;
            if (rdata !== 32'h0) begin
                n_err++; $display("FAIL reset_read_%h: got %h want 0", addrs[i], rdata);
            end
        end
    endtask

    task automatic test_outputs();
        wr(8'h08, 32'hFF);
        wr(8'h04, 32'hA5);
        wr(8'h0C, 32'h02);
        wr(8'h10, 32'h80);
        n_checks++;
        if (gpio_out !== 32'h27) begin n_err++; $display("FAIL set_clr_gpio_out: got %h want 27", gpio_out); end
        n_checks++;
        if (gpio_oe !== 32'hFF) begin n_err++; $display("FAIL dir_gpio_oe: got %h want ff", gpio_oe); end
        rd(8'h04);
        n_checks++;
        if (rdata !== 32'h27) begin n_err++; $display("FAIL data_out_read: got %h want 27", rdata); end
        rd(8'h0C);
        n_checks++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL out_set_reads_zero: got %h want 0", rdata); end
        wr(8'h24, 32'hFFFF_FFFF);
        rd(8'h24);
        n_checks++;
        if (rdata !== 32'h0 || gpio_out !== 32'h27) begin
            n_err++; $display("FAIL unmapped: got rdata %h out %h want 0 / 27", rdata, gpio_out);
        end
        cycle(1'b1, 1'b1, 8'h04, 32'h55, pins);
        n_checks++;
        if (rdata !== 32'h27 || gpio_out !== 32'h55) begin
            n_err++; $display("FAIL rd_wr_same_cycle: got rdata %h out %h want 27 / 55", rdata, gpio_out);
        end
    endtask

    task automatic test_rise_latency();
        wr(8'h08, 32'h0);
        wr(8'h14, 32'h1);
        wr(8'h18, 32'h0);
        repeat (LAT + 4) idle(32'h0);
        for (int i = 1; i <= LAT + 1; i++) begin
            idle(32'h1);
            n_checks++;
            if (irq !== (i >= LAT)) begin
                n_err++; $display("FAIL rise_latency_cyc%0d: got irq %b want %b", i, irq, (i >= LAT));
            end
        end
        rd(8'h1C);
        n_checks++;
        if (rdata !== 32'h1) begin n_err++; $display("FAIL rise_status: got %h want 1", rdata); end
        wr(8'h1C, 32'h1);
        n_checks++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got irq %b want 0", irq); end
        repeat (LAT + 6) idle(32'h0);
        rd(8'h1C);
        n_checks++;
        if (rdata !== 32'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL fall_no_set: got status %h irq %b want 0", rdata, irq);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] f1, f2;
        bit hit = 0;
        wr(8'h14, 32'h0);
        wr(8'h18, 32'h4);
        repeat (LAT + 6) idle(32'h4);
        for (int i = 0; i < 40 && !hit; i++) begin
            f1 = fin_at(vh.size() - 1);
            f2 = fin_at(vh.size() - 2);
            if (!f1[2] && f2[2]) hit = 1;
            else idle(32'h0);
        end
        n_checks++;
        if (!hit) begin
            n_err++; $display("FAIL collision_timeout: got no falling edge want one within 40 cycles");
        end else begin
            cycle(1'b1, 1'b0, 8'h1C, 32'h4, 32'h0);
            rd(8'h1C);
            n_checks++;
            if (rdata[2] !== 1'b1 || irq !== 1'b1) begin
                n_err++; $display("FAIL collision_set_wins: got status %h irq %b want bit2=1", rdata, irq);
            end
        end
        wr(8'h1C, 32'h4);
        n_checks++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL collision_clear: got irq %b want 0", irq); end
    endtask

    task automatic test_output_pins();
        logic [31:0] v;
        wr(8'h1C, 32'hFFFF_FFFF);
        wr(8'h08, 32'h8);
        wr(8'h14, 32'h8);
        wr(8'h18, 32'h8);
        for (int t = 0; t < 4; t++) begin
            v = (t % 2 == 0) ? 32'h8 : 32'h0;
            repeat (LAT + 6) idle(v);
            rd(8'h00);
            n_checks++;
            if ((rdata & 32'h8) !== v) begin
                n_err++; $display("FAIL outpin_data_in_%0d: got %h want %h", t, rdata & 32'h8, v);
            end
        end
        rd(8'h1C);
        n_checks++;
        if (rdata !== 32'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL outpin_no_status: got status %h irq %b want 0", rdata, irq);
        end
    endtask

    task automatic test_random();
        logic [7:0] addrs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h24};
        logic [31:0] p;
        int op;
        for (int i = 0; i < 400; i++) begin
            p = pins;
            if ($urandom_range(3) == 0) p[$urandom_range(7)] ^= 1'b1;
            op = $urandom_range(7);
            cycle(op < 3 || op == 5, op == 3 || op == 4 || op == 5,
                  addrs[$urandom_range(8)], $urandom(), p);
            n_checks++;
            if (gpio_out !== m_out || gpio_oe !== m_dir || irq !== (|m_status) || rdata !== m_rdata) begin
                n_err++;
                $display("FAIL random_cyc%0d: got out %h oe %h irq %b rdata %h want %h %h %b %h",
                         i, gpio_out, gpio_oe, irq, rdata, m_out, m_dir, |m_status, m_rdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        wr(8'h08, 32'h0);
        wr(8'h14, 32'hFFFF_FFFF);
        wr(8'h18, 32'hFFFF_FFFF);
        wr(8'h04, 32'h3C);
        repeat (LAT + 4) idle(pins ^ 32'h1);
        n_checks++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (irq !== 1'b0 || gpio_out !== 32'h0 || gpio_oe !== 32'h0 || rdata !== 32'h0) begin
            n_err++; $display("FAIL async_reset: got irq %b out %h oe %h rdata %h want all 0",
                              irq, gpio_out, gpio_oe, rdata);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (LAT + 4) idle(pins);
        rd(8'h1C);
        n_checks++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL post_reset_status: got %h want 0", rdata); end
        rd(8'h14);
        n_checks++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL post_reset_rise_en: got %h want 0", rdata); end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        pins = '0;
        do_reset();
        wr(8'h14, 32'h1);
        repeat (10) idle(32'h0);
        repeat (2) idle(32'h1);
        repeat (10) idle(32'h0);
        rd(8'h00);
        n_checks++;
        if (rdata[0] !== 1'b0 || irq !== 1'b0) begin
            n_err++; $display("FAIL debounce_glitch: got data_in %h irq %b want bit0=0 irq 0", rdata, irq);
        end
        repeat (S + DB + 2) idle(32'h1);
        rd(8'h00);
        n_checks++;
        if (rdata[0] !== 1'b1 || irq !== 1'b1) begin
            n_err++; $display("FAIL debounce_stable: got data_in %h irq %b want bit0=1 irq 1", rdata, irq);
        end
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_outputs();
        test_rise_latency();
        test_w1c_collision();
        test_output_pins();
        test_random();
        test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
